// File: rtl/bit_clk_pkg.sv
// Shared definitions for the bit clock recovery control blocks:
// sequencer state encoding and the default interval/period width.
package bit_clk_pkg;

    localparam int CLK_LEN_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_EST = 3'd1,
        ST_ACQUIRE   = 3'd2,
        ST_VERIFY    = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_HOLDOVER  = 3'd5
    } lock_state_e;

endpackage : bit_clk_pkg

// File: rtl/bit_lock_ctrl_if.sv
// Control/status bundle between the bit clock recovery datapath and its
// lock sequencer. The sequencer takes the slave view; the datapath side
// (or a bench standing in for it) takes the master view.
interface bit_lock_ctrl_if #(
    parameter int CLK_LEN = 24
);

    logic               enable;
    logic               restart_req;
    logic               edge_stb;
    logic [CLK_LEN-1:0] interval;
    logic [CLK_LEN-1:0] clk_freq;
    logic               freq_reset;
    logic               adj_en;
    logic               out_en;
    logic               locked;
    logic               lost_stb;
    logic [2:0]         state;
    logic [7:0]         err_cnt;

    modport master (
        output enable, restart_req, edge_stb, interval, clk_freq,
        input  freq_reset, adj_en, out_en, locked, lost_stb, state, err_cnt
    );

    modport slave (
        input  enable, restart_req, edge_stb, interval, clk_freq,
        output freq_reset, adj_en, out_en, locked, lost_stb, state, err_cnt
    );

endinterface : bit_lock_ctrl_if

// File: rtl/edge_qualifier.sv
// Combinational good/bad verdict for one measured edge interval against the
// current period estimate. An interval is good when an estimate exists, the
// interval is no shorter than the estimate minus its tolerance, and no longer
// than the longest legal run. Comparisons are done in a widened domain so the
// shifted estimate and interval+tolerance never wrap.
module edge_qualifier #(
    parameter int CLK_LEN   = 24,
    parameter int TOL_SHIFT = 3,
    parameter int RUN_SHIFT = 3
) (
    input  logic [CLK_LEN-1:0] interval,
    input  logic [CLK_LEN-1:0] clk_freq,
    output logic               good
);

    localparam int EXT_W = CLK_LEN + RUN_SHIFT + 1;

    logic [EXT_W-1:0] iv_ext;
    logic [EXT_W-1:0] cf_ext;
    logic [EXT_W-1:0] tol_ext;
    logic [EXT_W-1:0] max_run;
    logic             have_est;

    assign iv_ext   = EXT_W'(interval);
    assign cf_ext   = EXT_W'(clk_freq);
    assign tol_ext  = EXT_W'(clk_freq >> TOL_SHIFT);
    assign max_run  = cf_ext << RUN_SHIFT;
    // All-ones is the datapath's "no estimate yet" marker.
    assign have_est = (clk_freq != {CLK_LEN{1'b1}});

    // Lower bound uses interval+tol so no subtraction can underflow.
    assign good = have_est && ((iv_ext + tol_ext) >= cf_ext) && (iv_ext <= max_run);

endmodule : edge_qualifier

// File: rtl/bit_lock_ctrl.sv
// Acquisition/lock sequencer for the bit clock recovery datapath.
// Walks IDLE -> RESET_EST -> ACQUIRE -> VERIFY -> LOCKED <-> HOLDOVER,
// qualifying each falling-edge interval against the period estimate and
// falling back to re-acquisition on repeated bad edges or edge silence.
module bit_lock_ctrl
    import bit_clk_pkg::*;
#(
    parameter int CLK_LEN    = CLK_LEN_DEF,
    parameter int ACQ_EDGES  = 32,
    parameter int LOCK_EDGES = 16,
    parameter int MISS_LIMIT = 4,
    parameter int TOL_SHIFT  = 3,
    parameter int RUN_SHIFT  = 3,
    parameter int TIMEOUT    = 3000000
) (
    input  logic           clk_300M,
    input  logic           rst_n,
    bit_lock_ctrl_if.slave bus
);

    localparam int EW = $clog2(ACQ_EDGES + 1);
    localparam int GW = $clog2(LOCK_EDGES + 1);
    localparam int BW = $clog2(MISS_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [EW-1:0] ACQ_LAST  = EW'(ACQ_EDGES - 1);
    localparam logic [EW-1:0] ACQ_MAX   = EW'(ACQ_EDGES);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_EDGES - 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_EDGES);
    localparam logic [BW-1:0] BAD_LAST  = BW'(MISS_LIMIT - 1);
    localparam logic [BW-1:0] BAD_MAX   = BW'(MISS_LIMIT);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    lock_state_e   state_q;
    lock_state_e   nxt_state;
    logic          state_chg;

    logic [EW-1:0] edge_cnt_q;
    logic [GW-1:0] good_cnt_q;
    logic [BW-1:0] bad_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    err_cnt_q;

    logic          freq_reset_q;
    logic          adj_en_q;
    logic          out_en_q;
    logic          locked_q;
    logic          lost_stb_q;

    logic          edge_good;
    logic          good_edge;
    logic          bad_edge;
    logic          expired;
    logic          qual_state;

    function automatic logic [7:0] err_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    edge_qualifier #(
        .CLK_LEN   (CLK_LEN),
        .TOL_SHIFT (TOL_SHIFT),
        .RUN_SHIFT (RUN_SHIFT)
    ) u_edge_qualifier (
        .interval (bus.interval),
        .clk_freq (bus.clk_freq),
        .good     (edge_good)
    );

    assign good_edge  = bus.edge_stb && edge_good;
    assign bad_edge   = bus.edge_stb && !edge_good;
    // An edge arriving in the expiry cycle keeps the link alive.
    assign expired    = (tmo_cnt_q == TMO_MAX) && !bus.edge_stb;
    assign qual_state = (state_q == ST_VERIFY) || (state_q == ST_LOCKED) ||
                        (state_q == ST_HOLDOVER);
    assign state_chg  = (nxt_state != state_q);

    // Next-state selection: enable, then restart, then timeout, then edges.
    always_comb begin
        nxt_state = state_q;
        if (!bus.enable) begin
            nxt_state = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            nxt_state = ST_RESET_EST;
        end else if (bus.restart_req) begin
            nxt_state = ST_RESET_EST;
        end else begin
            case (state_q)
                ST_RESET_EST: nxt_state = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (expired)
                        nxt_state = ST_RESET_EST;
                    else if (bus.edge_stb && (edge_cnt_q == ACQ_LAST))
                        nxt_state = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (expired)
                        nxt_state = ST_RESET_EST;
                    else if (good_edge && (good_cnt_q == GOOD_LAST))
                        nxt_state = ST_LOCKED;
                    else if (bad_edge && (bad_cnt_q == BAD_LAST))
                        nxt_state = ST_RESET_EST;
                end
                ST_LOCKED: begin
                    if (expired || (bad_edge && (bad_cnt_q == BAD_LAST)))
                        nxt_state = ST_HOLDOVER;
                end
                ST_HOLDOVER: begin
                    if (expired)
                        nxt_state = ST_RESET_EST;
                    else if (good_edge && (good_cnt_q == GOOD_LAST))
                        nxt_state = ST_LOCKED;
                    else if (bad_edge && (bad_cnt_q == BAD_LAST))
                        nxt_state = ST_RESET_EST;
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    // State register with outputs decoded from the state being entered.
    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            freq_reset_q <= 1'b0;
            adj_en_q     <= 1'b0;
            out_en_q     <= 1'b0;
            locked_q     <= 1'b0;
            lost_stb_q   <= 1'b0;
        end else begin
            state_q      <= nxt_state;
            freq_reset_q <= (nxt_state == ST_RESET_EST);
            adj_en_q     <= (nxt_state == ST_VERIFY) || (nxt_state == ST_LOCKED);
            out_en_q     <= (nxt_state == ST_LOCKED) || (nxt_state == ST_HOLDOVER);
            locked_q     <= (nxt_state == ST_LOCKED);
            lost_stb_q   <= (state_q == ST_LOCKED) && (nxt_state == ST_HOLDOVER);
        end
    end

    // Edge, good-run and bad-run counters; all restart on any state change.
    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else if (state_chg) begin
            edge_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else if (bus.edge_stb) begin
            if (state_q == ST_ACQUIRE) begin
                if (edge_cnt_q != ACQ_MAX)
                    edge_cnt_q <= edge_cnt_q + 1'b1;
            end else if (qual_state) begin
                if (edge_good) begin
                    bad_cnt_q <= '0;
                    if (good_cnt_q != GOOD_MAX)
                        good_cnt_q <= good_cnt_q + 1'b1;
                end else begin
                    good_cnt_q <= '0;
                    if (bad_cnt_q != BAD_MAX)
                        bad_cnt_q <= bad_cnt_q + 1'b1;
                end
            end
        end
    end

    // Bad-edge tally since the last estimate reset; frozen when a disable
    // or restart overrides the edge in the same cycle.
    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (state_q == ST_RESET_EST) begin
            err_cnt_q <= '0;
        end else if (qual_state && bad_edge && bus.enable && !bus.restart_req) begin
            err_cnt_q <= err_sat_inc(err_cnt_q);
        end
    end

    // Edge-silence timer: restarts on each edge or state change, then saturates.
    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (bus.edge_stb || state_chg) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign bus.freq_reset = freq_reset_q;
    assign bus.adj_en     = adj_en_q;
    assign bus.out_en     = out_en_q;
    assign bus.locked     = locked_q;
    assign bus.lost_stb   = lost_stb_q;
    assign bus.state      = state_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule : bit_lock_ctrl

// File: tb/tb_bit_lock_ctrl.sv
// Bench for bit_lock_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_bit_lock_ctrl;

    localparam int CLK_LEN    = 24;
    localparam int ACQ_EDGES  = 4;
    localparam int LOCK_EDGES = 4;
    localparam int MISS_LIMIT = 2;
    localparam int TIMEOUT    = 100;
    localparam int NO_EST     = 32'h00FF_FFFF;

    logic clk;
    logic rst_n;

    bit_lock_ctrl_if #(.CLK_LEN(CLK_LEN)) bus_if();

    bit_lock_ctrl #(
        .CLK_LEN    (CLK_LEN),
        .ACQ_EDGES  (ACQ_EDGES),
        .LOCK_EDGES (LOCK_EDGES),
        .MISS_LIMIT (MISS_LIMIT),
        .TOL_SHIFT  (3),
        .RUN_SHIFT  (3),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_300M (clk),
        .rst_n    (rst_n),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: plain integers following the state rules.
    int m_state, m_edges, m_good, m_bad, m_silent, m_err;
    bit m_lost;

    typedef struct {
        bit          en;
        bit          rr;
        bit          es;
        int          iv;
        int          cf;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] pk(input int st, input bit fr, input bit adj,
                                       input bit oen, input bit lk, input bit lost,
                                       input int err);
        logic [2:0] s3;
        logic [7:0] e8;
        s3 = st[2:0];
        e8 = err[7:0];
        return {s3, fr, adj, oen, lk, lost, e8};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus_if.state, bus_if.freq_reset, bus_if.adj_en, bus_if.out_en,
                bus_if.locked, bus_if.lost_stb, bus_if.err_cnt};
    endfunction

    function automatic logic [15:0] model_vec();
        return pk(m_state, m_state == 1, (m_state == 3) || (m_state == 4),
                  (m_state == 4) || (m_state == 5), m_state == 4, m_lost, m_err);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_edges = 0; m_good = 0; m_bad = 0;
        m_silent = 0; m_err = 0; m_lost = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit rr, input bit es,
                              input int iv, input int cf);
        int  nxt;
        bit  good;
        bit  exp_now;
        good = (cf != NO_EST) && (longint'(iv) + longint'(cf / 8) >= longint'(cf))
               && (longint'(iv) <= longint'(cf) * 8);
        exp_now = (m_silent == TIMEOUT) && !es;
        nxt = m_state;
        if (!en)                nxt = 0;
        else if (m_state == 0)  nxt = 1;
        else if (rr)            nxt = 1;
        else if (m_state == 1)  nxt = 2;
        else if (m_state > 5)   nxt = 0;
        else if (exp_now)       nxt = (m_state == 4) ? 5 : 1;
        else if (es) begin
            case (m_state)
                2: if (m_edges + 1 == ACQ_EDGES) nxt = 3;
                3, 5: begin
                    if (good && m_good + 1 == LOCK_EDGES) nxt = 4;
                    if (!good && m_bad + 1 == MISS_LIMIT) nxt = 1;
                end
                4: if (!good && m_bad + 1 == MISS_LIMIT) nxt = 5;
                default: ;
            endcase
        end
        if (m_state == 1) m_err = 0;
        else if (en && !rr && es && !good && m_state >= 3 && m_state <= 5)
            m_err = (m_err < 255) ? m_err + 1 : 255;
        if (nxt != m_state) begin
            m_edges = 0; m_good = 0; m_bad = 0;
        end else if (es) begin
            if (m_state == 2) m_edges++;
            else if (m_state >= 3 && m_state <= 5) begin
                if (good) begin m_good++; m_bad = 0; end
                else      begin m_bad++;  m_good = 0; end
            end
        end
        if (es || nxt != m_state) m_silent = 0;
        else if (m_silent < TIMEOUT) m_silent++;
        m_lost  = (m_state == 4) && (nxt == 5);
        m_state = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, advance model and DUT, compare against model.
    task automatic drive(input bit en, input bit rr, input bit es, input int iv, input int cf);
        bus_if.enable      = en;
        bus_if.restart_req = rr;
        bus_if.edge_stb    = es;
        bus_if.interval    = iv[CLK_LEN-1:0];
        bus_if.clk_freq    = cf[CLK_LEN-1:0];
        model_step(en, rr, es, iv, cf);
        tick();
        check("model", dut_vec(), model_vec());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cf_seg;
        int  lo;
        int  iv;
        bit  es;
        bit  quiet;
        bit  found;

        rst_n = 1'b0;
        bus_if.enable = 1'b0; bus_if.restart_req = 1'b0; bus_if.edge_stb = 1'b0;
        bus_if.interval = '0; bus_if.clk_freq = '1;
        model_reset();
        repeat (3) tick();
        check("reset_state", dut_vec(), 16'h0000);
        rst_n = 1'b1;

        // Directed table: acquisition, verification, lock, loss and relock at clk_freq=80.
        tbl.push_back('{1, 0, 0,   0, 80, pk(1, 1, 0, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 0,   0, 80, pk(2, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(2, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(2, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(2, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(3, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(3, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1,  75, 80, pk(3, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1, 160, 80, pk(3, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{1, 0, 1, 640, 80, pk(4, 0, 1, 1, 1, 0, 0)});
        tbl.push_back('{1, 0, 1,  30, 80, pk(4, 0, 1, 1, 1, 0, 1)});
        tbl.push_back('{1, 0, 1,  30, 80, pk(5, 0, 0, 1, 0, 1, 2)});
        tbl.push_back('{1, 0, 0,   0, 80, pk(5, 0, 0, 1, 0, 0, 2)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(5, 0, 0, 1, 0, 0, 2)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(5, 0, 0, 1, 0, 0, 2)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(5, 0, 0, 1, 0, 0, 2)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(4, 0, 1, 1, 1, 0, 2)});
        tbl.push_back('{1, 0, 1,  69, 80, pk(4, 0, 1, 1, 1, 0, 3)});
        tbl.push_back('{1, 0, 1,  80, 80, pk(4, 0, 1, 1, 1, 0, 3)});
        tbl.push_back('{1, 0, 1,  69, 80, pk(4, 0, 1, 1, 1, 0, 4)});
        tbl.push_back('{1, 0, 1,  69, 80, pk(5, 0, 0, 1, 0, 1, 5)});
        tbl.push_back('{1, 0, 0,   0, 80, pk(5, 0, 0, 1, 0, 0, 5)});

        for (int i = 0; i < tbl.size(); i++) begin
            bus_if.enable      = tbl[i].en;
            bus_if.restart_req = tbl[i].rr;
            bus_if.edge_stb    = tbl[i].es;
            bus_if.interval    = tbl[i].iv[CLK_LEN-1:0];
            bus_if.clk_freq    = tbl[i].cf[CLK_LEN-1:0];
            model_step(tbl[i].en, tbl[i].rr, tbl[i].es, tbl[i].iv, tbl[i].cf);
            tick();
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Relock, then silence: LOCKED -> HOLDOVER -> RESET_EST via timeouts.
        repeat (4) drive(1, 0, 1, 80, 80);
        check("relock", {13'd0, bus_if.state}, 16'd4);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            drive(1, 0, 0, 0, 80);
            if (bus_if.state == 3'd1) found = 1'b1;
        end
        check("tmo_to_reset_state", {13'd0, bus_if.state}, 16'd1);
        check("tmo_freq_reset", {15'd0, bus_if.freq_reset}, 16'd1);

        // Edge landing exactly in the expiry cycle holds ACQUIRE.
        drive(1, 0, 0, 0, 80);
        repeat (TIMEOUT) drive(1, 0, 0, 0, 80);
        drive(1, 0, 1, 80, 80);
        check("edge_on_expiry", {13'd0, bus_if.state}, 16'd2);

        // Finish acquisition, then no-estimate edges are bad.
        repeat (ACQ_EDGES - 1) drive(1, 0, 1, 80, 80);
        check("to_verify", {13'd0, bus_if.state}, 16'd3);
        repeat (MISS_LIMIT) drive(1, 0, 1, 80, NO_EST);
        check("no_est_bad", {13'd0, bus_if.state}, 16'd1);

        // Restart during a good edge in LOCKED, then disable with restart.
        drive(1, 0, 0, 0, 80);
        repeat (ACQ_EDGES) drive(1, 0, 1, 80, 80);
        repeat (LOCK_EDGES) drive(1, 0, 1, 80, 80);
        check("locked_again", {13'd0, bus_if.state}, 16'd4);
        drive(1, 1, 1, 80, 80);
        check("restart_wins", {13'd0, bus_if.state}, 16'd1);
        drive(1, 0, 0, 0, 80);
        drive(0, 1, 0, 0, 80);
        check("disable_wins", {13'd0, bus_if.state}, 16'd0);

        // Asynchronous reset between clock edges while LOCKED.
        drive(1, 0, 0, 0, 80);
        drive(1, 0, 0, 0, 80);
        repeat (ACQ_EDGES + LOCK_EDGES) drive(1, 0, 1, 80, 80);
        check("locked_pre_rst", {13'd0, bus_if.state}, 16'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), 16'h0000);
        model_reset();
        tick();
        rst_n = 1'b1;

        // Randomized segments against the model.
        for (int seg = 0; seg < 20; seg++) begin
            cf_seg = ($urandom % 8 == 0) ? NO_EST : 40 + int'($urandom % 200);
            quiet  = ($urandom % 5 == 0);
            for (int c = 0; c < 150; c++) begin
                es = quiet ? ($urandom % 200 == 0) : ($urandom % 3 == 0);
                if (cf_seg == NO_EST) begin
                    iv = int'($urandom % 24'hFFFFFF);
                end else begin
                    lo = cf_seg - cf_seg / 8;
                    if ($urandom % 5 != 0)       iv = lo + int'($urandom % (2 * cf_seg));
                    else if ($urandom % 2 == 0)  iv = int'($urandom % lo);
                    else                         iv = cf_seg * 8 + 1 + int'($urandom % 100);
                end
                drive($urandom % 100 != 0, $urandom % 150 == 0, es, iv, cf_seg);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bit_lock_ctrl
